uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for 8N1 frames, oversampled at 16x. It sits directly downstream of the baud rate generator. It consumes the generator's `sample_enable` tick, recovers bytes from the `rx` pin, and presents each byte with a one-cycle valid pulse. Framing errors are flagged instead of delivered.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; legal range 5–8.
- `OVERSAMPLE`, 16: `sample_enable` ticks per bit period; must be even and ≥ 4.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `sample_enable` input 1: oversample tick from the baud rate generator, one `clk` wide.
- `rx` input 1: serial line, asynchronous to `clk`, idle high.
- `rx_data` output `DATA_BITS`: last correctly framed byte; holds until the next good frame.
- `rx_valid` output 1: one-`clk` pulse when `rx_data` is updated.
- `frame_error` output 1: one-`clk` pulse when the stop bit samples low.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`); both flops reset to 1.
- All state, counter and shift updates occur only on `clk` edges where `sample_enable`=1 (a "tick"). Output pulses clear on the next `clk` edge regardless of tick.
- `tick_cnt` is `$clog2(OVERSAMPLE)` bits wide. `bit_cnt` is `$clog2(DATA_BITS+1)` bits wide.
- States and transitions:
  - IDLE: on a tick with `rx_s`=0, go to START with `tick_cnt`=0. Otherwise stay.
  - START: increment `tick_cnt` each tick. On the tick where `tick_cnt`=`OVERSAMPLE/2-1` (mid start bit):
    - `rx_s`=1 is a glitch: go to IDLE, no outputs.
    - `rx_s`=0: go to DATA with `tick_cnt`=0, `bit_cnt`=0.
  - DATA: on the tick where `tick_cnt`=`OVERSAMPLE-1`:
    - shift `rx_s` into the MSB of `shift_reg` (shift right), so LSB-first reception ends aligned;
    - set `tick_cnt`=0 and increment `bit_cnt`;
    - when the shifted bit is bit `DATA_BITS-1`, go to STOP.
  - STOP: on the tick where `tick_cnt`=`OVERSAMPLE-1`:
    - `rx_s`=1: load `rx_data` from `shift_reg`, pulse `rx_valid`, go to IDLE;
    - `rx_s`=0: pulse `frame_error`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: on a tick with `rx_s`=1, go to IDLE. This prevents a held-low line (break) from being read as repeated start bits.
- `rx_valid` and `frame_error` are never asserted together.
- Back-to-back frames are supported: a start bit beginning immediately after a good stop-bit sample is detected on the next tick in IDLE.
- Reset mid-frame returns to IDLE and discards the partial byte. No pulse is emitted.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_error`=0;
  - state=IDLE, `tick_cnt`=0, `bit_cnt`=0, `shift_reg`=0, synchronizer=1,1.
- Synchronizer latency: 2 `clk` from the `rx` pin to `rx_s`.
- Each data bit is sampled `OVERSAMPLE/2 + k·OVERSAMPLE` ticks after start detection (k = 1..`DATA_BITS`), i.e. at bit centre.
- The stop bit is sampled `OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE` ticks after start detection: 152 ticks at the defaults.
- `rx_valid` / `frame_error` rise on the `clk` edge of the stop-sampling tick and fall on the following `clk` edge. `rx_data` is valid in the same cycle as `rx_valid`.
- `sample_enable` spacing may be any value ≥ 1 `clk`, including held high continuously. Behaviour is defined purely in ticks.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8, shared with the baud generator and the future transmitter.
- Sub-module `sync_2ff` (1-bit, reset value parameter) implements the synchronizer and is reused by other async inputs.

## Test plan
- Frame 0xA5 at 16 ticks/bit, `sample_enable` every 8 `clk` → `rx_data`=0xA5, `rx_valid` high exactly 1 `clk`, `frame_error` stays 0.
- `rx` low for 4 ticks then high (glitch) → no `rx_valid`, no `frame_error`, state back to IDLE; a following 0x3C frame is received correctly.
- Frame 0x5A with stop bit driven 0, then `rx` held low 40 ticks → single `frame_error` pulse, `rx_data` keeps its prior value, no `rx_valid`. After `rx` returns high, 0x81 is received.
- Back-to-back 0x00 then 0xFF with zero idle gap → two `rx_valid` pulses 160 ticks apart, data 0x00 then 0xFF.
- `rst` asserted during data bit 3 of 0x77 → all outputs 0 immediately, no pulse. A subsequent 0x12 frame is received correctly.
- `sample_enable` held high continuously, frame 0xC3 at 16 `clk`/bit → `rx_data`=0xC3 with `rx_valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver state encoding,
// common to the baud generator, receiver and transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL sets the
// value both flops take while rst is asserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: two stages, both held at RESET_VAL during reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled on sample_enable ticks; delivers each good
// byte with a one-cycle rx_valid pulse and flags bad stop bits with frame_error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_r;
  rx_state_t            state_nxt_s;
  logic [TW-1:0]        tick_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_error_r;
  logic                 mid_s;
  logic                 last_s;
  logic                 valid_nxt_s;
  logic                 ferr_nxt_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign mid_s  = sample_enable && (tick_cnt_r == MID_TICK);
  assign last_s = sample_enable && (tick_cnt_r == LAST_TICK);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; every transition is qualified by a tick
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_enable && !rx_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (mid_s) begin
          state_nxt_s = rx_s ? IDLE : DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (last_s && (bit_cnt_r == LAST_BIT)) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (last_s) begin
          state_nxt_s = rx_s ? IDLE : BREAK;
        end else begin
          state_nxt_s = STOP;
        end
      end
      // A held-low line stays here so it is never mistaken for a new start bit
      BREAK: begin
        if (sample_enable && rx_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BREAK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode: stop-bit verdict, exclusive by construction on rx_s
  always_comb begin
    valid_nxt_s = 1'b0;
    ferr_nxt_s  = 1'b0;
    if ((state_r == STOP) && last_s) begin
      valid_nxt_s = rx_s;
      ferr_nxt_s  = !rx_s;
    end else begin
      valid_nxt_s = 1'b0;
      ferr_nxt_s  = 1'b0;
    end
  end

  // Bit-timing counters, shift register and delivered byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      rx_data_r  <= '0;
    end else if (sample_enable) begin
      case (state_r)
        IDLE: begin
          tick_cnt_r <= '0;
        end
        START: begin
          if (tick_cnt_r == MID_TICK) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
          end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt_r == LAST_TICK) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= bit_cnt_r + BW'(1);
            shift_r    <= {rx_s, shift_r[DATA_BITS-1:1]};
          end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt_r == LAST_TICK) begin
            tick_cnt_r <= '0;
            if (rx_s) begin
              rx_data_r <= shift_r;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
          end
        end
        BREAK: begin
          tick_cnt_r <= '0;
        end
        default: begin
          tick_cnt_r <= '0;
        end
      endcase
    end
  end

  // Result pulses last exactly one clk, independent of tick spacing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_r    <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      rx_valid_r    <= valid_nxt_s;
      frame_error_r <= ferr_nxt_s;
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign frame_error = frame_error_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven tick-accurately on rx and a
// scoreboard queue of expected deliveries / framing errors is checked on each pulse.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = UART_OVERSAMPLE;
  localparam int DB = UART_DATA_BITS;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_enable;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;

  int   checks = 0;
  int   errors = 0;
  int   se_period = 8;
  int   tick_count = 0;
  exp_t exp_q[$];
  int   pulse_ticks[$];
  logic [7:0] model_data = 8'h00;
  logic prev_pulse = 1'b0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .sample_enable(sample_enable),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_error  (frame_error)
  );

  // Tick generator: one-clk pulse every se_period clocks, changed just after the edge
  initial begin
    int cnt;
    cnt = 0;
    sample_enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt >= se_period) begin
        cnt = 0;
        sample_enable = 1'b1;
      end else begin
        sample_enable = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (sample_enable === 1'b1) tick_count <= tick_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      model_data = 8'h00;
      prev_pulse = 1'b0;
    end else begin
      if (prev_pulse) check("pulse_width", {30'd0, rx_valid, frame_error}, 32'd0);
      if (rx_valid || frame_error) begin
        check("exclusive", 32'(rx_valid & frame_error), 32'd0);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pulse: observed valid=%0b ferr=%0b expected no pulse",
                 rx_valid, frame_error);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pulse_kind_ferr", 32'(frame_error), 32'(e.is_err));
          if (!e.is_err) model_data = e.data;
          check("rx_data", 32'(rx_data), 32'(model_data));
        end
        pulse_ticks.push_back(tick_count);
      end
      prev_pulse = rx_valid | frame_error;
    end
  end

  task automatic send_bit(input logic b, input int n);
    int c;
    c = 0;
    rx = b;
    while (c < n) begin
      @(posedge clk);
      if (sample_enable) c++;
    end
    #2;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    exp_t e;
    e.is_err = ~stop;
    e.data   = data;
    exp_q.push_back(e);
    send_bit(1'b0, OS);
    for (int i = 0; i < DB; i++) send_bit(data[i], OS);
    send_bit(stop, OS);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_state", 32'(dut.state_r), 32'(IDLE));
    rst = 1'b0;
    send_bit(1'b1, 4);

    // Basic frame, tick every 8 clk
    send_frame(8'hA5, 1'b1);
    send_bit(1'b1, 4);
    wait_drain("drain_a5");
    check("a5_data_held", 32'(rx_data), 32'hA5);

    // Short low glitch rejected at mid start bit
    send_bit(1'b0, 4);
    send_bit(1'b1, 20);
    check("glitch_state", 32'(dut.state_r), 32'(IDLE));
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1, 4);
    wait_drain("drain_3c");

    // Bad stop bit followed by a held-low break
    send_frame(8'h5A, 1'b0);
    send_bit(1'b0, 40);
    check("break_state", 32'(dut.state_r), 32'(BREAK));
    check("ferr_data_kept", 32'(rx_data), 32'h3C);
    send_bit(1'b1, 20);
    wait_drain("drain_5a");
    send_frame(8'h81, 1'b1);
    send_bit(1'b1, 4);
    wait_drain("drain_81");

    // Back-to-back frames, no idle between stop and next start
    pulse_ticks.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_bit(1'b1, 4);
    wait_drain("drain_b2b");
    check("b2b_pulses", 32'(pulse_ticks.size()), 32'd2);
    if (pulse_ticks.size() >= 2)
      check("b2b_spacing", 32'(pulse_ticks[1] - pulse_ticks[0]), 32'd160);

    // Reset in the middle of data bit 3 of 0x77
    send_bit(1'b0, OS);
    send_bit(1'b1, OS);
    send_bit(1'b1, OS);
    send_bit(1'b1, OS);
    send_bit(1'b0, OS / 2);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    check("midreset_frame_error", 32'(frame_error), 32'd0);
    check("midreset_state", 32'(dut.state_r), 32'(IDLE));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    send_bit(1'b1, 20);
    check("post_reset_data", 32'(rx_data), 32'h00);
    send_frame(8'h12, 1'b1);
    send_bit(1'b1, 4);
    wait_drain("drain_12");

    // sample_enable held high: one tick per clk
    se_period = 1;
    send_bit(1'b1, 8);
    send_frame(8'hC3, 1'b1);
    send_bit(1'b1, 8);
    wait_drain("drain_c3");
    check("c3_data_held", 32'(rx_data), 32'hC3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
